// File: rtl/darkbus_if.sv
// darkbus request/response bundle: level-enable request from the master, single-cycle
// valid strobe back from the responder, shared tri-state data.
interface darkbus_if;
  logic        bus_en;
  logic        bus_rw;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  wire  [31:0] bus_data;
  logic        bus_valid;
  logic        err;

  modport master (
    output bus_en, bus_rw, bus_be, bus_addr,
    inout  bus_data,
    input  bus_valid, err
  );

  modport slave (
    input  bus_en, bus_rw, bus_be, bus_addr,
    inout  bus_data,
    output bus_valid, err
  );
endinterface

// File: rtl/darkbus_sram_resp.sv
// darkbus responder serving a word-organised on-chip SRAM with byte-enable writes,
// programmable wait states and an address-window check.
module darkbus_sram_resp #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input logic      clk,
  input logic      res,
  darkbus_if.slave bus
);
  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  localparam int unsigned TAG_LSB = ADDR_BITS + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit         NO_WAIT  = (WAIT_STATES == 0);

  logic [1:0]           state_reg;
  logic [3:0]           cnt_reg;
  logic                 rw_reg;
  logic [3:0]           be_reg;
  logic [ADDR_BITS-1:0] idx_reg;
  logic                 hit_reg;
  logic [31:0]          wdata_reg;
  logic                 valid_reg;
  logic                 err_reg;
  logic [31:0]          rdata;

  logic                 hit_now;
  logic [ADDR_BITS-1:0] idx_now;
  logic                 enter_resp;
  logic                 c_rw;
  logic                 c_hit;
  logic [3:0]           c_be;
  logic [ADDR_BITS-1:0] c_idx;
  logic [31:0]          c_wdata;
  logic                 wr_commit;
  logic                 rd_commit;
  logic                 unused_addr_lsb;

  assign hit_now = (bus.bus_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign idx_now = bus.bus_addr[TAG_LSB-1:2];
  assign unused_addr_lsb = ^bus.bus_addr[1:0];

  // With no wait states the commit edge is also the acceptance edge, so the
  // commit uses the live request fields instead of the latched copies.
  assign enter_resp = res && bus.bus_en &&
                      ((state_reg == S_IDLE && NO_WAIT) ||
                       (state_reg == S_WAIT && cnt_reg == 4'd0));
  assign c_rw      = NO_WAIT ? bus.bus_rw   : rw_reg;
  assign c_hit     = NO_WAIT ? hit_now      : hit_reg;
  assign c_be      = NO_WAIT ? bus.bus_be   : be_reg;
  assign c_idx     = NO_WAIT ? idx_now      : idx_reg;
  assign c_wdata   = NO_WAIT ? bus.bus_data : wdata_reg;
  assign wr_commit = enter_resp && c_rw && c_hit;
  assign rd_commit = enter_resp && !c_rw;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (wr_commit && c_be[gi]) begin
          mem[c_idx] <= c_wdata[8*gi +: 8];
        end
        if (rd_commit) begin
          rd_byte_reg <= c_hit ? mem[c_idx] : ERR_DATA[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!res) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.bus_en) begin
            rw_reg    <= bus.bus_rw;
            be_reg    <= bus.bus_be;
            idx_reg   <= idx_now;
            hit_reg   <= hit_now;
            wdata_reg <= bus.bus_data;
            if (NO_WAIT) begin
              state_reg <= S_RESP;
              valid_reg <= 1'b1;
              err_reg   <= ~hit_now;
            end else begin
              state_reg <= S_WAIT;
              cnt_reg   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus.bus_en) begin
            state_reg <= S_IDLE;
          end else if (cnt_reg == 4'd0) begin
            state_reg <= S_RESP;
            valid_reg <= 1'b1;
            err_reg   <= ~hit_reg;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        S_RESP: state_reg <= S_HOLD;
        // Held until the master drops its level enable, so one request is served once.
        default: begin
          if (!bus.bus_en) begin
            state_reg <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.bus_valid = valid_reg;
  assign bus.err       = err_reg;
  assign bus.bus_data  = (state_reg == S_RESP && !rw_reg) ? rdata : 32'bz;
endmodule
